// File: rtl/scl_schmitt_pkg.sv
// Shared defaults, hysteresis state type and parameter legality check
// for the SCL Schmitt-trigger input filter.
package scl_schmitt_pkg;

   localparam int unsigned NCH_DEF   = 4;
   localparam int unsigned CNT_W_DEF = 4;
   localparam int unsigned HI_TH_DEF = 12;
   localparam int unsigned LO_TH_DEF = 3;

   typedef enum logic {
      ST_LOW  = 1'b0,
      ST_HIGH = 1'b1
   } hyst_state_t;

   // Thresholds must fit the counter and leave a non-empty hysteresis band.
   function automatic bit params_legal(input int unsigned nch,
                                       input int unsigned cnt_w,
                                       input int unsigned hi_th,
                                       input int unsigned lo_th);
      if (nch < 32'd1 || nch > 32'd32)      return 1'b0;
      if (cnt_w < 32'd2 || cnt_w > 32'd8)   return 1'b0;
      if (hi_th > ((32'd1 << cnt_w) - 32'd1)) return 1'b0;
      if (lo_th >= hi_th)                   return 1'b0;
      return 1'b1;
   endfunction

endpackage

// File: rtl/scl_schmitt_chan.sv
// One filter channel: 2-flop synchronizer, saturating up/down integrator,
// two-state hysteresis on the integrator value, registered edge pulses.
module scl_schmitt_chan
   import scl_schmitt_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned HI_TH = HI_TH_DEF,
   parameter int unsigned LO_TH = LO_TH_DEF
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_en,
   input  logic i_a,
   output logic o_x,
   output logic o_rise,
   output logic o_fall
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] HI      = CNT_W'(HI_TH);
   localparam logic [CNT_W-1:0] LO      = CNT_W'(LO_TH);

   logic [1:0]       r_sync;
   logic [CNT_W-1:0] r_cnt;
   hyst_state_t      r_state;
   logic             r_rise;
   logic             r_fall;

   logic             w_s;
   logic [CNT_W-1:0] w_cnt_next;
   hyst_state_t      w_state_next;
   logic             w_rise;
   logic             w_fall;

   assign w_s = r_sync[1];

   // Saturating integrator: counts toward the synchronized level.
   always_comb begin
      w_cnt_next = r_cnt;
      if (i_en) begin
         if (w_s && (r_cnt != CNT_MAX)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
         end else if (!w_s && (r_cnt != '0)) begin
            w_cnt_next = r_cnt - CNT_W'(1);
         end
      end
   end

   // Hysteresis decision is taken on the count being written this edge.
   always_comb begin
      w_state_next = r_state;
      w_rise       = 1'b0;
      w_fall       = 1'b0;
      if (i_en) begin
         case (r_state)
            ST_LOW: begin
               if (w_cnt_next >= HI) begin
                  w_state_next = ST_HIGH;
                  w_rise       = 1'b1;
               end
            end
            ST_HIGH: begin
               if (w_cnt_next <= LO) begin
                  w_state_next = ST_LOW;
                  w_fall       = 1'b1;
               end
            end
            default: w_state_next = ST_LOW;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync  <= '0;
         r_cnt   <= '0;
         r_state <= ST_LOW;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_a};
         r_cnt   <= w_cnt_next;
         r_state <= w_state_next;
         r_rise  <= w_rise;
         r_fall  <= w_fall;
      end
   end

   assign o_x    = (r_state == ST_HIGH);
   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule

// File: rtl/scl_schmitt_filter.sv
// Multi-channel Schmitt-trigger style glitch filter for asynchronous
// SCL/SDA-type inputs; every output comes straight from a flop.
module scl_schmitt_filter
   import scl_schmitt_pkg::*;
#(
   parameter int unsigned NCH   = NCH_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned HI_TH = HI_TH_DEF,
   parameter int unsigned LO_TH = LO_TH_DEF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           en,
   input  logic [NCH-1:0] a,
   output logic [NCH-1:0] x,
   output logic [NCH-1:0] rise,
   output logic [NCH-1:0] fall
);

   if (!params_legal(NCH, CNT_W, HI_TH, LO_TH)) begin : g_param_check
      $fatal(1, "scl_schmitt_filter: illegal NCH/CNT_W/HI_TH/LO_TH combination");
   end

   for (genvar i = 0; i < int'(NCH); i++) begin : g_chan
      scl_schmitt_chan #(
         .CNT_W (CNT_W),
         .HI_TH (HI_TH),
         .LO_TH (LO_TH)
      ) u_chan (
         .i_clk   (clk),
         .i_reset (reset),
         .i_en    (en),
         .i_a     (a[i]),
         .o_x     (x[i]),
         .o_rise  (rise[i]),
         .o_fall  (fall[i])
      );
   end

endmodule

// File: tb/tb_scl_schmitt_filter.sv
// Randomized and directed bench for scl_schmitt_filter: a default instance and
// a narrow 8-channel instance, both tracked by a cycle-level behavioural model.
module tb_scl_schmitt_filter;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [3:0] a0;
   logic [7:0] a1;
   logic [3:0] x0, rise0, fall0;
   logic [7:0] x1, rise1, fall1;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      bit s1;
      bit s2;
      int cnt;
      bit x;
      bit rise;
      bit fall;
   } mstate_t;

   mstate_t m0[4];
   mstate_t m1[8];

   always #5 clk = ~clk;

   scl_schmitt_filter u_dut0 (
      .clk(clk), .reset(reset), .en(en), .a(a0),
      .x(x0), .rise(rise0), .fall(fall0)
   );

   scl_schmitt_filter #(.NCH(8), .CNT_W(3), .HI_TH(6), .LO_TH(1)) u_dut1 (
      .clk(clk), .reset(reset), .en(en), .a(a1),
      .x(x1), .rise(rise1), .fall(fall1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // One clock of the reference: level sampled two edges late, counter walks
   // toward it within [0,mx], output flips only past the thresholds.
   function automatic mstate_t mstep(mstate_t st, bit rst, bit e, bit in,
                                     int hi, int lo, int mx);
      mstate_t n;
      n = st;
      if (rst) begin
         n = '{default: 0};
         return n;
      end
      n.s1   = in;
      n.s2   = st.s1;
      n.rise = 1'b0;
      n.fall = 1'b0;
      if (e) begin
         if (st.s2 && st.cnt < mx)        n.cnt = st.cnt + 1;
         else if (!st.s2 && st.cnt > 0)   n.cnt = st.cnt - 1;
         if (n.cnt >= hi)      n.x = 1'b1;
         else if (n.cnt <= lo) n.x = 1'b0;
         n.rise = n.x && !st.x;
         n.fall = !n.x && st.x;
      end
      return n;
   endfunction

   task automatic tick();
      logic [3:0] ex0, er0, ef0;
      logic [7:0] ex1, er1, ef1;
      @(posedge clk);
      for (int i = 0; i < 4; i++) m0[i] = mstep(m0[i], reset, en, a0[i], 12, 3, 15);
      for (int i = 0; i < 8; i++) m1[i] = mstep(m1[i], reset, en, a1[i], 6, 1, 7);
      #1;
      for (int i = 0; i < 4; i++) begin
         ex0[i] = m0[i].x; er0[i] = m0[i].rise; ef0[i] = m0[i].fall;
      end
      for (int i = 0; i < 8; i++) begin
         ex1[i] = m1[i].x; er1[i] = m1[i].rise; ef1[i] = m1[i].fall;
      end
      chk("x0",    32'(x0),    32'(ex0));
      chk("rise0", 32'(rise0), 32'(er0));
      chk("fall0", 32'(fall0), 32'(ef0));
      chk("x1",    32'(x1),    32'(ex1));
      chk("rise1", 32'(rise1), 32'(er1));
      chk("fall1", 32'(fall1), 32'(ef1));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int edge_x, edge_r, n_r, n_f, others, lost;
      int hold0[4];
      int hold1[8];

      for (int i = 0; i < 4; i++) m0[i] = '{default: 0};
      for (int i = 0; i < 8; i++) m1[i] = '{default: 0};
      reset = 1'b1; en = 1'b1; a0 = '0; a1 = '0;
      tick();
      tick();
      chk("reset_x0", 32'(x0), 32'd0);
      chk("reset_x1", 32'(x1), 32'd0);
      reset = 1'b0;

      // Rise latency on channel 0 from a clean reset.
      a0 = 4'b0001;
      edge_x = -1; edge_r = -1; n_r = 0; others = 0;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (x0[0] && edge_x < 0) edge_x = k;
         if (rise0[0] && edge_r < 0) edge_r = k;
         n_r += int'(rise0[0]);
         others += int'(|x0[3:1]) + int'(|rise0[3:1]) + int'(|fall0);
      end
      chk("rise_latency_x",    32'(edge_x), 32'd14);
      chk("rise_latency_rise", 32'(edge_r), 32'd14);
      chk("rise_pulse_count",  32'(n_r),    32'd1);
      chk("rise_other_chans",  32'(others), 32'd0);

      // Fall latency on channel 1 from saturation.
      a0 = 4'b0011;
      for (int k = 0; k < 20; k++) tick();
      chk("ch1_saturated_x", 32'(x0[1]), 32'd1);
      a0 = 4'b0001;
      edge_x = -1; n_f = 0;
      for (int k = 1; k <= 25; k++) begin
         tick();
         if (fall0[1] && edge_x < 0) edge_x = k;
         n_f += int'(fall0[1]);
      end
      chk("fall_latency", 32'(edge_x), 32'd14);
      chk("fall_pulse_count", 32'(n_f), 32'd1);

      // Drop for five edges, restore at edge 6: output must hold high.
      a0 = 4'b0011;
      for (int k = 0; k < 20; k++) tick();
      a0 = 4'b0001;
      lost = 0; n_f = 0;
      for (int k = 1; k <= 30; k++) begin
         if (k == 6) a0 = 4'b0011;
         tick();
         lost += int'(!x0[1]);
         n_f  += int'(fall0[1]);
      end
      chk("short_drop_hold", 32'(lost), 32'd0);
      chk("short_drop_fall", 32'(n_f),  32'd0);

      // Short high pulse from zero never qualifies.
      a0 = 4'b0000;
      do_reset();
      a0 = 4'b0001;
      n_r = 0; lost = 0;
      for (int k = 1; k <= 30; k++) begin
         if (k == 6) a0 = 4'b0000;
         tick();
         n_r  += int'(rise0[0]);
         lost += int'(x0[0]);
      end
      chk("glitch_no_rise", 32'(n_r),  32'd0);
      chk("glitch_x_low",   32'(lost), 32'd0);
      chk("glitch_cnt_drained", 32'(m0[0].cnt), 32'd0);

      // Enable pause at count 7, then five more enabled edges to set.
      do_reset();
      a0 = 4'b0001;
      for (int k = 0; k < 9; k++) tick();
      en = 1'b0;
      n_r = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         n_r += int'(|rise0) + int'(|fall0) + int'(x0[0]);
      end
      chk("pause_quiet", 32'(n_r), 32'd0);
      en = 1'b1;
      edge_x = -1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (x0[0] && edge_x < 0) edge_x = k;
      end
      chk("pause_resume_latency", 32'(edge_x), 32'd5);

      // Reset from x=1, cnt=10 discards state, then full latency again.
      for (int k = 0; k < 10; k++) tick();
      a0 = 4'b0000;
      for (int k = 0; k < 40 && m0[0].cnt != 10; k++) tick();
      chk("pre_reset_x", 32'(x0[0]), 32'd1);
      do_reset();
      chk("post_reset_x",    32'(x0[0]),    32'd0);
      chk("post_reset_fall", 32'(fall0[0]), 32'd0);
      a0 = 4'b0001;
      edge_x = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (x0[0] && edge_x < 0) edge_x = k;
      end
      chk("post_reset_latency", 32'(edge_x), 32'd14);

      // Every channel toggling each cycle stays low on both instances.
      do_reset();
      a0 = 4'b0101; a1 = 8'h55;
      lost = 0;
      for (int k = 0; k < 200; k++) begin
         tick();
         lost += int'(|x1) + int'(|rise1) + int'(|fall1) + int'(|x0);
         a0 = ~a0; a1 = ~a1;
      end
      chk("toggle_quiet", 32'(lost), 32'd0);

      // Random run lengths per channel, occasional enable gaps and resets.
      for (int i = 0; i < 4; i++) hold0[i] = 0;
      for (int i = 0; i < 8; i++) hold1[i] = 0;
      for (int k = 0; k < 4000; k++) begin
         for (int i = 0; i < 4; i++) begin
            if (hold0[i] == 0) begin
               a0[i] = ~a0[i];
               hold0[i] = int'($urandom_range(40, 1));
            end
            hold0[i]--;
         end
         for (int i = 0; i < 8; i++) begin
            if (hold1[i] == 0) begin
               a1[i] = ~a1[i];
               hold1[i] = int'($urandom_range(20, 1));
            end
            hold1[i]--;
         end
         en    = ($urandom_range(15, 0) != 0);
         reset = ($urandom_range(499, 0) == 0);
         tick();
      end
      reset = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
